sar_search_16b: RTL

SAR_SEARCH_16B -- requirements
Module: sar_search_16b

---
 rtl/sar_search_16b.sv | 112 +++++++++++
 1 files changed

// File: rtl/sar_search_16b.sv
// 16-bit successive-approximation search driving an external comparator, MSB first.
// Optional SAR_EARLY_EXIT_EN: finish as soon as the comparator reports equality.
module sar_search_16b (
  input  logic        clk,
  input  logic        rst_n,
  input  logic        start,
  input  logic        cmp_gt,
  input  logic        cmp_lt,
  input  logic        cmp_eq,
  output logic [15:0] cand,
  output logic        busy,
  output logic        done,
  output logic [15:0] result,
  output logic        exact,
  output logic        err
);

  typedef enum logic [1:0] {S_IDLE, S_SEARCH, S_DONE} state_t;

  state_t      state_q, state_d;
  logic [15:0] acc_q, acc_d;
  logic [3:0]  idx_q, idx_d;
  logic [15:0] cand_q, cand_d;
  logic [15:0] result_q, result_d;
  logic        exact_q, exact_d;
  logic        err_q, err_d;

  logic [15:0] bit_sel;
  logic [15:0] acc_upd;
  logic        code_ok;

  // gt or eq both mean target >= cand, so the trial bit is kept
  assign bit_sel = 16'h0001 << idx_q;
  assign acc_upd = cmp_lt ? acc_q : (acc_q | bit_sel);
  assign code_ok = ({cmp_gt, cmp_lt, cmp_eq} == 3'b100) ||
                   ({cmp_gt, cmp_lt, cmp_eq} == 3'b010) ||
                   ({cmp_gt, cmp_lt, cmp_eq} == 3'b001);

  always_comb begin
    state_d  = state_q;
    acc_d    = acc_q;
    idx_d    = idx_q;
    cand_d   = cand_q;
    result_d = result_q;
    exact_d  = exact_q;
    err_d    = err_q;
    case (state_q)
      S_IDLE: begin
        if (start) begin
          state_d = S_SEARCH;
          acc_d   = 16'h0000;
          idx_d   = 4'd15;
          cand_d  = 16'h8000;
          exact_d = 1'b0;
          err_d   = 1'b0;
        end
      end
      S_SEARCH: begin
        if (!code_ok) begin
          // abort with only the bits decided before this trial
          result_d = acc_q;
          err_d    = 1'b1;
          state_d  = S_DONE;
`ifdef SAR_EARLY_EXIT_EN
        end else if (cmp_eq) begin
          result_d = cand_q;
          exact_d  = 1'b1;
          state_d  = S_DONE;
`endif
        end else if (idx_q == 4'd0) begin
          result_d = acc_upd;
          exact_d  = cmp_eq;
          state_d  = S_DONE;
        end else begin
          acc_d  = acc_upd;
          idx_d  = idx_q - 4'd1;
          cand_d = acc_upd | (bit_sel >> 1);
        end
      end
      S_DONE: state_d = S_IDLE;
      default: state_d = S_IDLE;
    endcase
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q  <= S_IDLE;
      acc_q    <= 16'h0000;
      idx_q    <= 4'd0;
      cand_q   <= 16'h0000;
      result_q <= 16'h0000;
      exact_q  <= 1'b0;
      err_q    <= 1'b0;
    end else begin
      state_q  <= state_d;
      acc_q    <= acc_d;
      idx_q    <= idx_d;
      cand_q   <= cand_d;
      result_q <= result_d;
      exact_q  <= exact_d;
      err_q    <= err_d;
    end
  end

  assign cand   = cand_q;
  assign busy   = (state_q == S_SEARCH);
  assign done   = (state_q == S_DONE);
  assign result = result_q;
  assign exact  = exact_q;
  assign err    = err_q;

endmodule
